sum_7seg_driver: RTL and testbench
==================================

# sum_7seg_driver

- Output stage downstream of the 4-bit ripple adder: captures the 5-bit sum (0..31) on a load strobe and shows it as two decimal digits on a time-multiplexed common-anode 7-segment display.
- Adder outputs are unregistered; this block provides the hold register, binary-to-decimal split, digit refresh counter and segment drive for the board.

## Interface

Parameters:
- REFRESH_DIV, default 50000: clock cycles each digit is enabled before switching; legal range ≥1.
- BLANK_LZ, default 1: when 1, the tens digit is blanked for values 0..9.

Ports:
- CLK  input  1: single clock; all state is updated on the rising edge.
- RST_N  input  1: asynchronous, active-low reset.
- SUM  input  5: adder result {carry, sum[3:0]}; sampled only when LOAD=1.
- LOAD  input  1: capture strobe, one cycle per capture.
- SEG  output  7: segment drive {g,f,e,d,c,b,a}, active-low; registered.
- AN  output  2: digit enables, active-low; AN[0] = ones, AN[1] = tens; registered.
- OVF  output  1: registered copy of the held SUM[4], i.e. the adder carry.

## Operation

- Held register `val[4:0]` loads SUM on any edge where LOAD=1. With LOAD on consecutive cycles, every edge loads and the last one wins. When LOAD=0, `val` holds.
- Decimal split is combinational: tens = `val`/10 (0..3), ones = `val`%10. Both are 4-bit, computed by comparison/subtraction with no divider.
- Refresh counter `cnt` counts 0..REFRESH_DIV-1 and wraps to 0. On the wrap edge, the digit select `sel` toggles (0 = ones, 1 = tens).
  - For REFRESH_DIV=1, `cnt` stays 0 and `sel` toggles every cycle.
- Output registers are updated every edge from the current `sel`/`val`:
  - `sel`=0: AN=2'b10, SEG=decode(ones).
  - `sel`=1: AN=2'b01, SEG=decode(tens), except SEG=7'b1111111 when BLANK_LZ=1 and `val`<10.
  - OVF=`val`[4].
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other input = 1111111.
- Reset (asynchronous, any time, including mid-refresh or coincident with LOAD):
  - Internal: `val`=0, `cnt`=0, `sel`=0.
  - Outputs: SEG=7'b1000000, AN=2'b10, OVF=0.
  - LOAD is ignored while RST_N=0. Normal operation resumes on the first rising edge after RST_N deasserts.

## Timing

- Capture latency: LOAD high at edge k, so `val` is updated at edge k. SEG/OVF reflect the new value after edge k+1 for whichever digit is selected at that point. The other digit follows at its next enable slot.
- Digit switch: `sel` toggles at edge k, so AN/SEG change together after edge k+1. AN and SEG are always mutually consistent, with no mixed-digit cycle.
- Each digit is enabled for exactly REFRESH_DIV consecutive cycles; the full frame is 2×REFRESH_DIV cycles.
- LOAD coincident with a digit switch: both take effect. The output after edge k+1 shows the new value on the new digit.
- Exactly one AN bit is low at all times after reset.

## Structure

- Shared package `sum_disp_pkg`:
  - Segment pattern constants `SEG_DIGIT[0:9]` and `SEG_BLANK`.
  - AN encodings `AN_ONES` / `AN_TENS`.
  - Counter width function: `$clog2(REFRESH_DIV)`, minimum 1.
- One sub-module, `seg7_decoder`: 4-bit digit in, 7-bit active-low pattern out, purely combinational. It is instantiated once and fed the digit selected by `sel`.
- The binary split, counter, select and output registers live in `sum_7seg_driver`.

## Test plan

- Reset with REFRESH_DIV=4, release, no LOAD. Required: AN alternates 10/01 every 4 cycles. Ones digit SEG=1000000, tens digit SEG=1111111, OVF=0.
- LOAD with SUM=23. Required: ones slot SEG=0110000 ("3"), tens slot SEG=0100100 ("2"), OVF=1. First change appears one cycle after the LOAD edge.
- SUM=7 with BLANK_LZ=1, then with BLANK_LZ=0. Required: ones slot 1111000. Tens slot 1111111 with blanking, 1000000 without.
- LOAD pulses with SUM=30, 15, 31 on three consecutive cycles. Required: display settles to "31" with OVF=1; the intermediate values are each visible for one cycle only.
- Assert RST_N low mid-frame while LOAD=1 with SUM=19. Required: outputs go to 1000000 / 10 / 0 asynchronously, and the value 19 is never displayed after release.
- REFRESH_DIV=1 with SUM=12 loaded. Required: AN toggles every cycle, SEG alternates between 0100100 and 1111001.

Source files
------------

// File: rtl/sum_disp_pkg.sv
// Shared constants for the sum display path: segment patterns, digit
// enable encodings and the refresh counter width helper.
package sum_disp_pkg;

   // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9.
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low digit enables: bit 0 drives the ones digit, bit 1 the tens.
   localparam logic [1:0] AN_ONES = 2'b10;
   localparam logic [1:0] AN_TENS = 2'b01;

   // Refresh counter width; a divide of 1 still needs a 1-bit counter.
   function automatic int cnt_width(input int div);
      return (div <= 1) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_decoder
   import sum_disp_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   // Table lookup, defaulting to blank for codes 10..15.
   always_comb begin
      seg_o = SEG_BLANK;
      for (int i = 0; i < 10; i++) begin
         if (digit_i == 4'(i)) seg_o = SEG_DIGIT[i];
      end
   end

endmodule

// File: rtl/sum_7seg_driver.sv
// Holds the adder result on LOAD and shows it as two multiplexed decimal
// digits on a common-anode display, with the carry on OVF.
module sum_7seg_driver
   import sum_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [4:0] SUM,
   input  logic       LOAD,
   output logic [6:0] SEG,
   output logic [1:0] AN,
   output logic       OVF
);

   localparam int            CW       = cnt_width(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   logic [4:0]    val_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic          ovf_q;

   logic [3:0]    tens, ones, digit;
   logic [6:0]    dec_seg;
   logic          wrap;

   // Binary to two decimal digits by range compare; val never exceeds 31.
   always_comb begin
      tens = 4'd0;
      ones = val_q[3:0];
      if (val_q >= 5'd30) begin
         tens = 4'd3;
         ones = 4'(val_q - 5'd30);
      end else if (val_q >= 5'd20) begin
         tens = 4'd2;
         ones = 4'(val_q - 5'd20);
      end else if (val_q >= 5'd10) begin
         tens = 4'd1;
         ones = 4'(val_q - 5'd10);
      end
   end

   // One shared decoder fed by whichever digit is currently selected.
   assign digit = sel_q ? tens : ones;

   seg7_decoder u_dec (
      .digit_i (digit),
      .seg_o   (dec_seg)
   );

   // Next-state for refresh timing and the output stage.
   always_comb begin
      wrap  = (cnt_q == CNT_LAST);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      sel_d = sel_q ^ wrap;
      an_d  = sel_q ? AN_TENS : AN_ONES;
      seg_d = dec_seg;
      if (sel_q && BLANK_LZ && (val_q < 5'd10)) seg_d = SEG_BLANK;
   end

   // Hold register: last LOAD wins, otherwise keep the value.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)    val_q <= '0;
      else if (LOAD) val_q <= SUM;
   end

   // Refresh counter and digit select; select flips on the wrap edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
         sel_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end

   // Output registers: AN and SEG come from the same sel, so they never mix.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         seg_q <= SEG_DIGIT[0];
         an_q  <= AN_ONES;
         ovf_q <= 1'b0;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
         ovf_q <= val_q[4];
      end
   end

   assign SEG = seg_q;
   assign AN  = an_q;
   assign OVF = ovf_q;

endmodule

// File: tb/tb_sum_7seg_driver.sv
// Directed bench for sum_7seg_driver: three instances (4-cycle refresh with
// and without leading-zero blanking, 1-cycle refresh) share one stimulus.
module tb_sum_7seg_driver;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       LOAD = 1'b0;
   logic [4:0] SUM = 5'd0;

   logic [6:0] seg4, segn, seg1;
   logic [1:0] an4, ann, an1;
   logic       ovf4, ovfn, ovf1;

   always #5 CLK = ~CLK;

   sum_7seg_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_d4 (
      .CLK(CLK), .RST_N(RST_N), .SUM(SUM), .LOAD(LOAD),
      .SEG(seg4), .AN(an4), .OVF(ovf4));
   sum_7seg_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dn (
      .CLK(CLK), .RST_N(RST_N), .SUM(SUM), .LOAD(LOAD),
      .SEG(segn), .AN(ann), .OVF(ovfn));
   sum_7seg_driver #(.REFRESH_DIV(1), .BLANK_LZ(1'b1)) u_d1 (
      .CLK(CLK), .RST_N(RST_N), .SUM(SUM), .LOAD(LOAD),
      .SEG(seg1), .AN(an1), .OVF(ovf1));

   // Hand-entered decode table, active-low {g..a}.
   logic [6:0] tbl [0:9];
   initial begin
      tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
      tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
      tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
      tbl[9] = 7'b0010000;
   end

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s @%0t: got %h exp %h", tag, $time, got, exp);
      end
   endtask

   // Reference: edges since reset, the held value, and the value the output
   // stage saw one edge ago (the one currently on the display).
   int         t = 0;
   logic [4:0] mval = 5'd0, shown = 5'd0;
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         t <= 0; mval <= 5'd0; shown <= 5'd0;
      end else begin
         t <= t + 1;
         shown <= mval;
         if (LOAD) mval <= SUM;
      end
   end

   function automatic logic [9:0] exp_out(input int div, input bit blank);
      logic [6:0] s;
      bit         tens_slot;
      int         v;
      v = int'(shown);
      tens_slot = (t != 0) && ((((t - 1) / div) % 2) == 1);
      if (!tens_slot)                 s = tbl[v % 10];
      else if (blank && v < 10)       s = 7'b1111111;
      else                            s = tbl[v / 10];
      return {tens_slot ? 2'b01 : 2'b10, s, shown[4]};
   endfunction

   task automatic chk_all();
      chk("d4",  {6'd0, an4, seg4, ovf4}, {6'd0, exp_out(4, 1'b1)});
      chk("dnb", {6'd0, ann, segn, ovfn}, {6'd0, exp_out(4, 1'b0)});
      chk("d1",  {6'd0, an1, seg1, ovf1}, {6'd0, exp_out(1, 1'b1)});
   endtask

   task automatic step();
      @(negedge CLK);
      chk_all();
   endtask

   // Step until the 4-cycle instance shows the wanted digit enable.
   task automatic wait_an(input logic [1:0] want);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (an4 == want) hit = 1'b1;
         else step();
      end
      if (!hit) chk("wait_an_timeout", 16'd0, 16'd1);
   endtask

   logic [1:0] an_prev;

   initial begin
      // Reset state.
      repeat (3) step();
      chk("rst_seg", {9'd0, seg4}, {9'd0, 7'b1000000});
      chk("rst_an",  {14'd0, an4}, {14'd0, 2'b10});
      RST_N = 1'b1;

      // Idle alternation: 10 for 4 cycles, 01 for 4, ...
      repeat (16) step();

      // 23: OVF changes one cycle after the LOAD edge.
      SUM = 5'd23; LOAD = 1'b1;
      step();
      chk("ld23_lat", {15'd0, ovf4}, 16'd0);
      LOAD = 1'b0;
      step();
      chk("ld23_ovf", {15'd0, ovf4}, 16'd1);
      wait_an(2'b10);
      chk("ld23_ones", {9'd0, seg4}, {9'd0, 7'b0110000});
      wait_an(2'b01);
      chk("ld23_tens", {9'd0, seg4}, {9'd0, 7'b0100100});

      // 7: tens blanked only with BLANK_LZ.
      SUM = 5'd7; LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      repeat (3) step();
      wait_an(2'b01);
      chk("s7_tens_blk", {9'd0, seg4}, {9'd0, 7'b1111111});
      chk("s7_tens_nob", {9'd0, segn}, {9'd0, 7'b1000000});
      wait_an(2'b10);
      chk("s7_ones", {9'd0, seg4}, {9'd0, 7'b1111000});

      // Back-to-back loads: last wins.
      SUM = 5'd30; LOAD = 1'b1;
      step();
      SUM = 5'd15;
      step();
      SUM = 5'd31;
      step();
      LOAD = 1'b0;
      repeat (6) step();
      wait_an(2'b10);
      chk("s31_ones", {9'd0, seg4}, {9'd0, 7'b1111001});
      chk("s31_ovf", {15'd0, ovf4}, 16'd1);
      wait_an(2'b01);
      chk("s31_tens", {9'd0, seg4}, {9'd0, 7'b0110000});

      // Asynchronous reset mid-frame, coincident with LOAD of 19.
      repeat (2) step();
      SUM = 5'd19; LOAD = 1'b1;
      #2 RST_N = 1'b0;
      #1;
      chk("arst_seg", {9'd0, seg4}, {9'd0, 7'b1000000});
      chk("arst_an",  {14'd0, an4}, {14'd0, 2'b10});
      chk("arst_ovf", {15'd0, ovf4}, 16'd0);
      chk_all();
      step();
      RST_N = 1'b1; LOAD = 1'b0;
      repeat (10) step();
      chk("post_rst_ovf", {15'd0, ovf4}, 16'd0);

      // 12 on the 1-cycle refresh instance.
      SUM = 5'd12; LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         an_prev = an1;
         step();
         chk("d1_toggle", {14'd0, an_prev ^ an1}, {14'd0, 2'b11});
         chk("d1_seg", {9'd0, seg1},
             {9'd0, (an1 == 2'b10) ? 7'b0100100 : 7'b1111001});
      end

      // Sweep every value so each digit pattern appears in both slots.
      for (int v = 0; v < 32; v++) begin
         SUM = 5'(v); LOAD = 1'b1;
         step();
         LOAD = 1'b0;
         repeat (8) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
